// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, fetch-ahead
// request position and a delayed display position with sync and line/frame pulses.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FP       = 210,
  parameter int unsigned H_SYNC     = 40,
  parameter int unsigned H_BP       = 6,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 22,
  parameter int unsigned V_SYNC     = 20,
  parameter int unsigned V_BP       = 4,
  parameter int unsigned HS_POL     = 0,
  parameter int unsigned VS_POL     = 0,
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned PIPE_DELAY = 2,
  parameter int unsigned COL_W      = 12,
  parameter int unsigned ROW_W      = 11
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  output logic             pix_tick_o,
  output logic [COL_W-1:0] req_col_o,
  output logic [ROW_W-1:0] req_row_o,
  output logic             req_valid_o,
  output logic [COL_W-1:0] disp_col_o,
  output logic [ROW_W-1:0] disp_row_o,
  output logic             visible_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic             line_start_o,
  output logic             frame_start_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = 4;
  localparam int unsigned ROW_LSB = 3;
  localparam int unsigned COL_LSB = 3 + ROW_W;
  localparam int unsigned PW      = COL_W + ROW_W + 3;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COL_W-1:0] H_LAST   = COL_W'(H_TOTAL - 1);
  localparam logic [ROW_W-1:0] V_LAST   = ROW_W'(V_TOTAL - 1);
  localparam logic [COL_W:0]   H_ACT_X  = (COL_W+1)'(H_ACTIVE);
  localparam logic [COL_W:0]   HS_BEG_X = (COL_W+1)'(H_ACTIVE + H_FP);
  localparam logic [COL_W:0]   HS_END_X = (COL_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [ROW_W:0]   V_ACT_X  = (ROW_W+1)'(V_ACTIVE);
  localparam logic [ROW_W:0]   VS_BEG_X = (ROW_W+1)'(V_ACTIVE + V_FP);
  localparam logic [ROW_W:0]   VS_END_X = (ROW_W+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_POL_B = 1'(HS_POL);
  localparam logic             VS_POL_B = 1'(VS_POL);

  // Entry layout {col, row, valid, hs_raw, vs_raw}. Stage 0 doubles as the
  // h/v counters (request side); stage PIPE_DELAY is the display side.
  logic [PW-1:0]    pipe_q [PIPE_DELAY+1];
  logic [PW-1:0]    pipe_d [PIPE_DELAY+1];
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_c;
  logic [COL_W-1:0] hcnt_q, hcnt_d, disp_col_d;
  logic [ROW_W-1:0] vcnt_q, vcnt_d, disp_row_d;
  logic             req_valid_d, hs_raw_d, vs_raw_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  assign hcnt_q = pipe_q[0][COL_LSB +: COL_W];
  assign vcnt_q = pipe_q[0][ROW_LSB +: ROW_W];

  always_comb begin
    tick_c        = enable_i && !reset_i && (div_q == DIV_LAST);
    div_d         = div_q;
    hcnt_d        = hcnt_q + 1'b1;
    vcnt_d        = vcnt_q;
    req_valid_d   = 1'b0;
    hs_raw_d      = 1'b0;
    vs_raw_d      = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (enable_i) begin
      div_d = tick_c ? '0 : div_q + 1'b1;
    end

    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end

    req_valid_d = ({1'b0, hcnt_d} < H_ACT_X) && ({1'b0, vcnt_d} < V_ACT_X);
    hs_raw_d    = ({1'b0, hcnt_d} >= HS_BEG_X) && ({1'b0, hcnt_d} < HS_END_X);
    vs_raw_d    = ({1'b0, vcnt_d} >= VS_BEG_X) && ({1'b0, vcnt_d} < VS_END_X);

    pipe_d[0] = {hcnt_d, vcnt_d, req_valid_d, hs_raw_d, vs_raw_d};
    for (int i = 1; i <= int'(PIPE_DELAY); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    // A pulse needs a real transition into column 0, so the zero-filled
    // pipeline right after reset does not fire spurious starts.
    disp_col_d    = pipe_d[PIPE_DELAY][COL_LSB +: COL_W];
    disp_row_d    = pipe_d[PIPE_DELAY][ROW_LSB +: ROW_W];
    line_start_d  = tick_c && (disp_col_d == '0) && (disp_col_o != '0);
    frame_start_d = line_start_d && (disp_row_d == '0);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      div_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      for (int i = 0; i <= int'(PIPE_DELAY); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      div_q         <= div_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      if (tick_c) begin
        for (int i = 0; i <= int'(PIPE_DELAY); i++) begin
          pipe_q[i] <= pipe_d[i];
        end
      end
    end
  end

  assign pix_tick_o    = tick_c;
  assign req_col_o     = hcnt_q;
  assign req_row_o     = vcnt_q;
  assign req_valid_o   = pipe_q[0][2];
  assign disp_col_o    = pipe_q[PIPE_DELAY][COL_LSB +: COL_W];
  assign disp_row_o    = pipe_q[PIPE_DELAY][ROW_LSB +: ROW_W];
  assign visible_o     = pipe_q[PIPE_DELAY][2];
  assign hs_o          = ~(pipe_q[PIPE_DELAY][1] ^ HS_POL_B);
  assign vs_o          = ~(pipe_q[PIPE_DELAY][0] ^ VS_POL_B);
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed-vector bench for vga_timing_gen on a 16x8 raster (H 8/2/3/3, V 4/1/2/1)
// in three configurations: baseline, CLK_DIV=3, and inverted polarity with no pipeline.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_pix, a_rv, a_vis, a_hs, a_vs, a_ls, a_fs;
  logic [3:0] a_rc, a_dc;
  logic [2:0] a_rr, a_dr;
  logic        b_pix, b_rv, b_vis, b_hs, b_vs, b_ls, b_fs;
  logic [11:0] b_rc, b_dc;
  logic [10:0] b_rr, b_dr;
  logic       c_pix, c_rv, c_vis, c_hs, c_vs, c_ls, c_fs;
  logic [4:0] c_rc, c_dc;
  logic [3:0] c_rr, c_dr;

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .HS_POL(0), .VS_POL(0), .CLK_DIV(1), .PIPE_DELAY(2),
                   .COL_W(4), .ROW_W(3)) dut_a (
    .clock_i(clk), .reset_i(rst), .enable_i(en), .pix_tick_o(a_pix),
    .req_col_o(a_rc), .req_row_o(a_rr), .req_valid_o(a_rv),
    .disp_col_o(a_dc), .disp_row_o(a_dr), .visible_o(a_vis),
    .hs_o(a_hs), .vs_o(a_vs), .line_start_o(a_ls), .frame_start_o(a_fs));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .HS_POL(0), .VS_POL(0), .CLK_DIV(3), .PIPE_DELAY(2),
                   .COL_W(12), .ROW_W(11)) dut_b (
    .clock_i(clk), .reset_i(rst), .enable_i(en), .pix_tick_o(b_pix),
    .req_col_o(b_rc), .req_row_o(b_rr), .req_valid_o(b_rv),
    .disp_col_o(b_dc), .disp_row_o(b_dr), .visible_o(b_vis),
    .hs_o(b_hs), .vs_o(b_vs), .line_start_o(b_ls), .frame_start_o(b_fs));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .HS_POL(1), .VS_POL(1), .CLK_DIV(1), .PIPE_DELAY(0),
                   .COL_W(5), .ROW_W(4)) dut_c (
    .clock_i(clk), .reset_i(rst), .enable_i(en), .pix_tick_o(c_pix),
    .req_col_o(c_rc), .req_row_o(c_rr), .req_valid_o(c_rv),
    .disp_col_o(c_dc), .disp_row_o(c_dr), .visible_o(c_vis),
    .hs_o(c_hs), .vs_o(c_vs), .line_start_o(c_ls), .frame_start_o(c_fs));

  typedef struct {
    int n;
    int rc, rr, rv;
    int dc, dr, vis;
    int hs, vs, ls, fs;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    step();
    step();
    rst = 1'b0;
    en  = 1'b1;
  endtask

  initial begin
    int n;
    int cnt_fs, cnt_ls, cnt_vis, cnt_hs, cnt_vs, bad_hs, bad_vs, bad_ls, bad_pix;
    int bad_tick, bad_col, bad_dcol, bad_eq, bad_sync, bad_vis, frz_bad, k;
    int erc, err;

    //             n   rc rr rv  dc dr vis hs vs ls fs
    tbl[0]  = '{  1,  1, 0, 1,  0, 0, 0,  1, 1, 0, 0};
    tbl[1]  = '{  2,  2, 0, 1,  0, 0, 0,  1, 1, 0, 0};
    tbl[2]  = '{  3,  3, 0, 1,  1, 0, 1,  1, 1, 0, 0};
    tbl[3]  = '{  7,  7, 0, 1,  5, 0, 1,  1, 1, 0, 0};
    tbl[4]  = '{  8,  8, 0, 0,  6, 0, 1,  1, 1, 0, 0};
    tbl[5]  = '{ 10, 10, 0, 0,  8, 0, 0,  1, 1, 0, 0};
    tbl[6]  = '{ 12, 12, 0, 0, 10, 0, 0,  0, 1, 0, 0};
    tbl[7]  = '{ 14, 14, 0, 0, 12, 0, 0,  0, 1, 0, 0};
    tbl[8]  = '{ 15, 15, 0, 0, 13, 0, 0,  1, 1, 0, 0};
    tbl[9]  = '{ 16,  0, 1, 1, 14, 0, 0,  1, 1, 0, 0};
    tbl[10] = '{ 18,  2, 1, 1,  0, 1, 1,  1, 1, 1, 0};
    tbl[11] = '{ 19,  3, 1, 1,  1, 1, 1,  1, 1, 0, 0};
    tbl[12] = '{ 66,  2, 4, 0,  0, 4, 0,  1, 1, 1, 0};
    tbl[13] = '{ 82,  2, 5, 0,  0, 5, 0,  1, 0, 1, 0};
    tbl[14] = '{114,  2, 7, 0,  0, 7, 0,  1, 1, 1, 0};
    tbl[15] = '{127, 15, 7, 0, 13, 7, 0,  1, 1, 0, 0};
    tbl[16] = '{128,  0, 0, 1, 14, 7, 0,  1, 1, 0, 0};
    tbl[17] = '{130,  2, 0, 1,  0, 0, 1,  1, 1, 1, 1};
    tbl[18] = '{131,  3, 0, 1,  1, 0, 1,  1, 1, 0, 0};

    // Reset state, with enable high so a CLK_DIV=1 tick would otherwise show.
    rst = 1'b1;
    en  = 1'b1;
    step();
    step();
    chk("rst_pix", int'(a_pix), 0);
    chk("rst_rc", int'(a_rc), 0);
    chk("rst_rr", int'(a_rr), 0);
    chk("rst_rv", int'(a_rv), 0);
    chk("rst_dc", int'(a_dc), 0);
    chk("rst_vis", int'(a_vis), 0);
    chk("rst_hs", int'(a_hs), 1);
    chk("rst_vs", int'(a_vs), 1);
    chk("rst_ls", int'(a_ls), 0);
    chk("rst_fs", int'(a_fs), 0);
    chk("rst_c_hs", int'(c_hs), 0);
    chk("rst_c_vs", int'(c_vs), 0);
    chk("rst_b_pix", int'(b_pix), 0);

    // Table vectors: n is the pixel-tick count since reset release.
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 19; i++) begin
      while (n < tbl[i].n) begin
        step();
        n++;
      end
      chk($sformatf("v%0d_rc", tbl[i].n), int'(a_rc), tbl[i].rc);
      chk($sformatf("v%0d_rr", tbl[i].n), int'(a_rr), tbl[i].rr);
      chk($sformatf("v%0d_rv", tbl[i].n), int'(a_rv), tbl[i].rv);
      chk($sformatf("v%0d_dc", tbl[i].n), int'(a_dc), tbl[i].dc);
      chk($sformatf("v%0d_dr", tbl[i].n), int'(a_dr), tbl[i].dr);
      chk($sformatf("v%0d_vis", tbl[i].n), int'(a_vis), tbl[i].vis);
      chk($sformatf("v%0d_hs", tbl[i].n), int'(a_hs), tbl[i].hs);
      chk($sformatf("v%0d_vs", tbl[i].n), int'(a_vs), tbl[i].vs);
      chk($sformatf("v%0d_ls", tbl[i].n), int'(a_ls), tbl[i].ls);
      chk($sformatf("v%0d_fs", tbl[i].n), int'(a_fs), tbl[i].fs);
    end

    // Two full frames of display positions.
    cnt_fs = 0; cnt_ls = 0; cnt_vis = 0; cnt_hs = 0; cnt_vs = 0;
    bad_hs = 0; bad_vs = 0; bad_ls = 0; bad_pix = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (a_fs) cnt_fs++;
      if (a_ls) cnt_ls++;
      if (a_vis) cnt_vis++;
      if (!a_hs) cnt_hs++;
      if (!a_vs) cnt_vs++;
      if ((!a_hs) != (a_dc >= 4'd10 && a_dc <= 4'd12)) bad_hs++;
      if ((!a_vs) != (a_dr >= 3'd5 && a_dr <= 3'd6)) bad_vs++;
      if (a_ls != (a_dc == 4'd0)) bad_ls++;
      if (!a_pix) bad_pix++;
    end
    chk("frames_fs", cnt_fs, 2);
    chk("frames_ls", cnt_ls, 16);
    chk("frames_vis", cnt_vis, 64);
    chk("frames_hs_low", cnt_hs, 48);
    chk("frames_vs_low", cnt_vs, 64);
    chk("hs_window", bad_hs, 0);
    chk("vs_window", bad_vs, 0);
    chk("ls_at_col0", bad_ls, 0);
    chk("pix_every_clk", bad_pix, 0);

    // Enable dropped while lineStart is high: pulse clears, position holds.
    do_reset();
    for (int i = 0; i < 18; i++) step();
    chk("en_ls_before", int'(a_ls), 1);
    en = 1'b0;
    step();
    chk("en_ls_cleared", int'(a_ls), 0);
    chk("en_pix_off", int'(a_pix), 0);
    chk("en_hold_rc", int'(a_rc), 2);
    chk("en_hold_dc", int'(a_dc), 0);
    en = 1'b1;
    step();
    chk("en_resume_rc", int'(a_rc), 3);
    chk("en_resume_dc", int'(a_dc), 1);

    // Enable dropped for 5 clocks at reqCol=7 of row 1.
    for (int i = 0; i < 4; i++) step();
    chk("frz_pre_rc", int'(a_rc), 7);
    chk("frz_pre_dc", int'(a_dc), 5);
    en = 1'b0;
    frz_bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (a_rc != 4'd7 || a_dc != 4'd5 || a_rr != 3'd1 || a_pix || a_ls || a_fs) frz_bad++;
    end
    chk("frz_held", frz_bad, 0);
    en = 1'b1;
    step();
    chk("frz_resume_rc", int'(a_rc), 8);
    chk("frz_resume_dc", int'(a_dc), 6);
    chk("frz_resume_rr", int'(a_rr), 1);

    // Asynchronous reset mid-frame at row 3, column 9.
    do_reset();
    for (int i = 0; i < 57; i++) step();
    chk("mid_rc", int'(a_rc), 9);
    chk("mid_rr", int'(a_rr), 3);
    chk("mid_dc", int'(a_dc), 7);
    chk("mid_vis", int'(a_vis), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_rc", int'(a_rc), 0);
    chk("arst_rr", int'(a_rr), 0);
    chk("arst_dc", int'(a_dc), 0);
    chk("arst_dr", int'(a_dr), 0);
    chk("arst_vis", int'(a_vis), 0);
    chk("arst_rv", int'(a_rv), 0);
    chk("arst_pix", int'(a_pix), 0);
    step();
    rst = 1'b0;
    step();
    chk("arst_first_rc", int'(a_rc), 1);
    chk("arst_first_rr", int'(a_rr), 0);
    chk("arst_first_rv", int'(a_rv), 1);

    // CLK_DIV=3: tick every third clock, line period 48 clocks.
    do_reset();
    bad_tick = 0; bad_col = 0; bad_dcol = 0;
    for (int j = 1; j <= 60; j++) begin
      step();
      k = j / 3;
      if (b_pix != ((j % 3) == 2)) bad_tick++;
      if (int'(b_rc) != k % 16 || int'(b_rr) != k / 16) bad_col++;
      if (int'(b_dc) != ((k <= 2) ? 0 : (k - 2) % 16)) bad_dcol++;
      if (j == 48) begin
        chk("div_line_rc", int'(b_rc), 0);
        chk("div_line_rr", int'(b_rr), 1);
      end
    end
    chk("div_tick_pattern", bad_tick, 0);
    chk("div_req_pos", bad_col, 0);
    chk("div_disp_lag", bad_dcol, 0);

    // Active-high sync, no pipeline: display matches request after each tick.
    do_reset();
    bad_eq = 0; bad_sync = 0; bad_vis = 0; cnt_ls = 0; cnt_fs = 0;
    for (int i = 1; i <= 128; i++) begin
      step();
      erc = i % 16;
      err = (i / 16) % 8;
      if (int'(c_dc) != erc || int'(c_dr) != err || int'(c_rc) != erc) bad_eq++;
      if (c_hs != (erc >= 10 && erc <= 12)) bad_sync++;
      if (c_vs != (err >= 5 && err <= 6)) bad_sync++;
      if (c_vis != (erc < 8 && err < 4)) bad_vis++;
      if (c_ls) cnt_ls++;
      if (c_fs) cnt_fs++;
    end
    chk("pol_disp_eq_req", bad_eq, 0);
    chk("pol_sync", bad_sync, 0);
    chk("pol_vis", bad_vis, 0);
    chk("pol_ls_count", cnt_ls, 8);
    chk("pol_fs_count", cnt_fs, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 210, 40, 6, horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 22, 20, 4, vertical porch and sync in lines.
REQ-005 SHALL have parameters HS_POL, VS_POL, default 0; 0 = active-low sync, 1 = active-high.
REQ-006 SHALL have parameter CLK_DIV, default 1 (range 1..16), clocks per pixel tick.
REQ-007 SHALL have parameter PIPE_DELAY, default 2 (range 0..8), pixel ticks by which the request outputs lead the display outputs.
REQ-008 SHALL have parameters COL_W, default 12, and ROW_W, default 11, counter widths.
REQ-009 clock  in  1  single clock for all logic.
REQ-010 reset  in  1  asynchronous, active-high reset.
REQ-011 enable  in  1  1 = timing runs; 0 = all state frozen.
REQ-012 pixTick  out  1  high for one clock per pixel period.
REQ-013 reqCol, reqRow  out  COL_W, ROW_W  pixel position to fetch now.
REQ-014 reqValid  out  1  reqCol/reqRow lie inside the active area.
REQ-015 dispCol, dispRow  out  COL_W, ROW_W  pixel position being displayed now.
REQ-016 visible  out  1  dispCol/dispRow lie inside the active area.
REQ-017 hs, vs  out  1  sync outputs at the configured polarity.
REQ-018 lineStart, frameStart  out  1  one-clock pulses at display column 0, and at display column 0 of row 0.

Function
REQ-019 The clock divider SHALL count 0..CLK_DIV-1 while enable=1 and raise pixTick on the clock where it equals CLK_DIV-1; CLK_DIV=1 SHALL give pixTick=enable.
REQ-020 On each pixTick, hCnt SHALL step 0..H_TOTAL-1 and wrap to 0, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-021 On the pixTick where hCnt wraps, vCnt SHALL step 0..V_TOTAL-1 and wrap to 0, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-022 reqCol=hCnt and reqRow=vCnt; reqValid SHALL equal (hCnt<H_ACTIVE && vCnt<V_ACTIVE).
REQ-023 The raw sync terms SHALL be: hsRaw true for H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC; vsRaw true for V_ACTIVE+V_FP <= vCnt < V_ACTIVE+V_FP+V_SYNC.
REQ-024 {hCnt, vCnt, reqValid, hsRaw, vsRaw} SHALL pass through a PIPE_DELAY-stage shift register that advances only on pixTick.
REQ-025 At the pipeline output, dispCol, dispRow and visible SHALL be registered, and hs = hsRaw XNOR HS_POL, vs = vsRaw XNOR VS_POL.
REQ-026 Display outputs SHALL equal the request outputs exactly PIPE_DELAY pixel ticks earlier; with PIPE_DELAY=0 they SHALL be equal one clock after each tick.
REQ-027 lineStart SHALL pulse for one clock when dispCol becomes 0; frameStart SHALL pulse for one clock when dispCol and dispRow both become 0.
REQ-028 With enable=0, counters, pipeline and outputs SHALL hold; pulses SHALL be 0; when enable returns, timing SHALL resume with no skipped or repeated pixel.
REQ-029 Counter arithmetic SHALL stay within COL_W/ROW_W; the design SHALL require H_TOTAL <= 2^COL_W and V_TOTAL <= 2^ROW_W.
REQ-030 Sync SHALL run continuously across frame wrap, with no extra line or pixel at any boundary.

Reset
REQ-031 While reset=1, the divider, hCnt, vCnt, all pipeline stages, dispCol, dispRow, reqCol and reqRow SHALL be 0.
REQ-032 While reset=1, visible, reqValid, pixTick, lineStart and frameStart SHALL be 0, and hs/vs SHALL be inactive (hs=~HS_POL, vs=~VS_POL).
REQ-033 A reset asserted mid-frame SHALL take effect immediately; after release, the first pixTick SHALL step from position (0,0).

Verification (H 8/2/3/3, V 4/1/2/1, CLK_DIV=1, PIPE_DELAY=2, pols 0 unless stated)
REQ-034 Release reset, enable=1 -> reqCol sequence 1..15,0 with reqRow stepping every 16 ticks; dispCol lags by 2 ticks; hs low exactly for dispCol 10..12.
REQ-035 Run 2 frames -> vs low for dispRow 5..6 only, frameStart once every 128 ticks, lineStart once every 16 ticks, visible high for 32 ticks per frame.
REQ-036 CLK_DIV=3 -> pixTick every 3rd clock; all outputs change only on the clock after a tick; line period is 48 clocks.
REQ-037 Drop enable for 5 clocks at reqCol=7 -> outputs frozen; on resume reqCol steps to 8 and dispCol continues from 5.
REQ-038 Assert reset at row 3, column 9 -> all outputs at reset values in the same clock; after release the timing restarts at (0,0).
REQ-039 HS_POL=1, VS_POL=1, PIPE_DELAY=0 -> hs/vs inverted relative to REQ-034 timing, and dispCol equals reqCol one clock after each tick.
